irrig_bcd_timer: RTL and testbench



---
 rtl/irrig_bcd_timer.sv | 166 ++++++++++++++++
 tb/tb_irrig_bcd_timer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrig_bcd_timer.sv
// Loadable multi-digit BCD countdown timer for the irrigation valve-on period.
// Optional MM:SS digit-1 limit, on-chip prescaler, IDLE/RUN/HOLD/DONE control
// and one-cycle step/done pulses for the controller and display cascade.
module irrig_bcd_timer #(
  parameter int unsigned DIGITS   = 4,
  parameter bit          MMSS     = 1'b1,
  parameter int unsigned PRESCALE = 50000000,
  parameter int unsigned PAUSE_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [PAUSE_W-1:0]    pause,
  output logic [4*DIGITS-1:0]   count,
  output logic [1:0]            state,
  output logic                  running,
  output logic                  reach_zero,
  output logic                  done,
  output logic                  step
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          step_q, step_d;
  logic          done_q, done_d;
  logic          running_q, running_d;
  logic          presc_wrap;

  // Highest legal value of digit i (seconds-tens stops at 5 in MM:SS mode)
  function automatic logic [3:0] dig_max(input int i);
    return (MMSS && (i == 1)) ? 4'd5 : 4'd9;
  endfunction

  // Saturate every preset digit to its legal range
  function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic [3:0]    d;
    r = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = v[4*i +: 4];
      r[4*i +: 4] = (d > dig_max(i)) ? dig_max(i) : d;
    end
    return r;
  endfunction

  // One BCD decrement: zero digits wrap to their max and pass the borrow up
  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic [3:0]    d;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = dig_max(i);
        end else begin
          r[4*i +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign presc_wrap = (presc_q == PW'(PRESCALE - 1));

  // Next-state: load > stop > start > pause; prescaler/count move only in RUN
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    step_d    = 1'b0;
    done_d    = 1'b0;
    running_d = 1'b0;
    if (load) begin
      count_d = bcd_clamp(preset);
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (count_q != '0)) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_IDLE;
            presc_d = '0;
          end else begin
            if (presc_wrap) begin
              presc_d = '0;
              count_d = bcd_dec(count_q);
              step_d  = 1'b1;
            end else begin
              presc_d = presc_q + PW'(1);
            end
            if (presc_wrap && (count_d == '0)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else if (|pause) begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (stop) begin
            state_d = ST_IDLE;
            presc_d = '0;
          end else if (pause == '0) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
  end

  // State, count, prescaler and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      step_q    <= step_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign count      = count_q;
  assign state      = state_q;
  assign running    = running_q;
  assign reach_zero = (count_q == '0);
  assign done       = done_q;
  assign step       = step_q;

endmodule

// File: tb/tb_irrig_bcd_timer.sv
// Self-checking bench for irrig_bcd_timer: directed vector table, hand
// sequences for hold/reset/two-digit decimal mode, and a randomized run
// against a seconds-based reference model.
module tb_irrig_bcd_timer;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;
  localparam int PRE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        load, start, stop;
  logic [15:0] preset;
  logic [2:0]  pause;
  logic [15:0] count;
  logic [1:0]  state;
  logic        running, reach_zero, done, step;

  logic        load2, start2, stop2;
  logic [7:0]  preset2;
  logic [2:0]  pause2;
  logic [7:0]  count2;
  logic [1:0]  state2;
  logic        running2, reach_zero2, done2, step2;

  irrig_bcd_timer #(.DIGITS(4), .MMSS(1'b1), .PRESCALE(PRE), .PAUSE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .preset(preset), .start(start),
    .stop(stop), .pause(pause), .count(count), .state(state), .running(running),
    .reach_zero(reach_zero), .done(done), .step(step));

  irrig_bcd_timer #(.DIGITS(2), .MMSS(1'b0), .PRESCALE(1), .PAUSE_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .preset(preset2), .start(start2),
    .stop(stop2), .pause(pause2), .count(count2), .state(state2), .running(running2),
    .reach_zero(reach_zero2), .done(done2), .step(step2));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: count held as total seconds (MM:SS, up to 99:59)
  int m_val, m_pc, m_st;
  bit m_step, m_done;
  bit use_model = 1'b0;

  function automatic int min9(input int d, input int m);
    return (d > m) ? m : d;
  endfunction

  function automatic int clamp_val(input logic [15:0] p);
    int d0, d1, d2, d3;
    d0 = min9(int'(p[3:0]), 9);
    d1 = min9(int'(p[7:4]), 5);
    d2 = min9(int'(p[11:8]), 9);
    d3 = min9(int'(p[15:12]), 9);
    return d0 + 10 * d1 + 60 * (d2 + 10 * d3);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    int s, m;
    s = v % 60;
    m = v / 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_val = 0; m_pc = 0; m_st = 0; m_step = 1'b0; m_done = 1'b0;
  endtask

  // Apply the current inputs to the model as one clock edge
  task automatic model_edge();
    m_step = 1'b0;
    m_done = 1'b0;
    if (load) begin
      m_val = clamp_val(preset); m_st = 0; m_pc = 0;
    end else if (m_st == 0) begin
      if (start && m_val != 0) begin m_st = 1; m_pc = 0; end
    end else if (m_st == 1) begin
      if (stop) begin
        m_st = 0; m_pc = 0;
      end else if (m_pc == PRE - 1) begin
        m_pc = 0; m_val = m_val - 1; m_step = 1'b1;
        if (m_val == 0) begin m_st = 3; m_done = 1'b1; end
        else if (pause != 3'b000) m_st = 2;
      end else begin
        m_pc = m_pc + 1;
        if (pause != 3'b000) m_st = 2;
      end
    end else if (m_st == 2) begin
      if (stop) begin m_st = 0; m_pc = 0; end
      else if (pause == 3'b000) m_st = 1;
    end
  endtask

  task automatic cmp_model();
    check("rnd_count", 32'(count), 32'(to_bcd(m_val)));
    check("rnd_state", 32'(state), 32'(m_st));
    check("rnd_done", 32'(done), 32'(m_done));
    check("rnd_step", 32'(step), 32'(m_step));
    check("rnd_running", 32'(running), 32'(m_st == 1));
    check("rnd_reach_zero", 32'(reach_zero), 32'(m_val == 0));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    if (use_model) cmp_model();
  endtask

  task automatic idle_inputs();
    load = 1'b0; start = 1'b0; stop = 1'b0; pause = 3'b000; preset = 16'h0000;
  endtask

  typedef struct {
    logic        ld;
    logic [15:0] pre;
    logic        st;
    logic        sp;
    logic [2:0]  ps;
    logic [15:0] e_cnt;
    logic [1:0]  e_st;
    logic        e_done;
    logic        e_step;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ld, input logic [15:0] pre, input logic st,
                              input logic sp, input logic [2:0] ps, input logic [15:0] c,
                              input logic [1:0] s, input logic d, input logic p);
    vec_t v;
    v.ld = ld; v.pre = pre; v.st = st; v.sp = sp; v.ps = ps;
    v.e_cnt = c; v.e_st = s; v.e_done = d; v.e_step = p;
    return v;
  endfunction

  task automatic nop_rows(input int n, input logic [15:0] c, input logic [1:0] s);
    for (int k = 0; k < n; k++) vecs.push_back(mk(0, 16'h0, 0, 0, 3'b000, c, s, 0, 0));
  endtask

  initial begin
    // 1:00 -> 0:59 after four RUN cycles
    vecs.push_back(mk(1, 16'h0100, 0, 0, 3'b000, 16'h0100, S_IDLE, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 3'b000, 16'h0100, S_RUN, 0, 0));
    nop_rows(3, 16'h0100, S_RUN);
    vecs.push_back(mk(0, 16'h0000, 0, 0, 3'b000, 16'h0059, S_RUN, 0, 1));
    nop_rows(1, 16'h0059, S_RUN);
    // 2 -> 1 -> 0, done pulse, start ignored in DONE
    vecs.push_back(mk(1, 16'h0002, 0, 0, 3'b000, 16'h0002, S_IDLE, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 3'b000, 16'h0002, S_RUN, 0, 0));
    nop_rows(3, 16'h0002, S_RUN);
    vecs.push_back(mk(0, 16'h0000, 0, 0, 3'b000, 16'h0001, S_RUN, 0, 1));
    nop_rows(3, 16'h0001, S_RUN);
    vecs.push_back(mk(0, 16'h0000, 0, 0, 3'b000, 16'h0000, S_DONE, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 3'b000, 16'h0000, S_DONE, 0, 0));
    // clamping and start on zero
    vecs.push_back(mk(1, 16'hFA7C, 0, 0, 3'b000, 16'h9959, S_IDLE, 0, 0));
    vecs.push_back(mk(1, 16'h0000, 0, 0, 3'b000, 16'h0000, S_IDLE, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 3'b000, 16'h0000, S_IDLE, 0, 0));
    // stop+start while running, restart with cleared prescaler
    vecs.push_back(mk(1, 16'h0005, 0, 0, 3'b000, 16'h0005, S_IDLE, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 3'b000, 16'h0005, S_RUN, 0, 0));
    nop_rows(1, 16'h0005, S_RUN);
    vecs.push_back(mk(0, 16'h0000, 1, 1, 3'b000, 16'h0005, S_IDLE, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 3'b000, 16'h0005, S_RUN, 0, 0));
    nop_rows(3, 16'h0005, S_RUN);
    vecs.push_back(mk(0, 16'h0000, 0, 0, 3'b000, 16'h0004, S_RUN, 0, 1));
    // stop on the step that would reach zero
    vecs.push_back(mk(1, 16'h0001, 0, 0, 3'b000, 16'h0001, S_IDLE, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 3'b000, 16'h0001, S_RUN, 0, 0));
    nop_rows(3, 16'h0001, S_RUN);
    vecs.push_back(mk(0, 16'h0000, 0, 1, 3'b000, 16'h0001, S_IDLE, 0, 0));
    // load on a step cycle
    vecs.push_back(mk(1, 16'h0003, 0, 0, 3'b000, 16'h0003, S_IDLE, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 3'b000, 16'h0003, S_RUN, 0, 0));
    nop_rows(3, 16'h0003, S_RUN);
    vecs.push_back(mk(1, 16'h0007, 0, 0, 3'b000, 16'h0007, S_IDLE, 0, 0));
    // pause on a step cycle: step still applies, HOLD next
    vecs.push_back(mk(0, 16'h0000, 1, 0, 3'b000, 16'h0007, S_RUN, 0, 0));
    nop_rows(3, 16'h0007, S_RUN);
    vecs.push_back(mk(0, 16'h0000, 0, 0, 3'b001, 16'h0006, S_HOLD, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 3'b000, 16'h0006, S_RUN, 0, 0));

    idle_inputs();
    load2 = 1'b0; start2 = 1'b0; stop2 = 1'b0; pause2 = 3'b000; preset2 = 8'h00;
    rst_n = 1'b0;
    model_reset();
    #12;
    check("rst_count", 32'(count), 32'h0);
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_running", 32'(running), 32'h0);
    check("rst_reach_zero", 32'(reach_zero), 32'h1);
    check("rst_done", 32'(done), 32'h0);
    check("rst_step", 32'(step), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed vector table
    foreach (vecs[i]) begin
      load = vecs[i].ld; preset = vecs[i].pre; start = vecs[i].st;
      stop = vecs[i].sp; pause = vecs[i].ps;
      tick();
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].e_st));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d_step", i), 32'(step), 32'(vecs[i].e_step));
      check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].e_st == S_RUN));
      check($sformatf("vec%0d_rz", i), 32'(reach_zero), 32'(vecs[i].e_cnt == 16'h0));
    end
    idle_inputs();

    // hold: prescaler frozen at 2 across a 10-cycle pause
    load = 1'b1; preset = 16'h0030; tick(); idle_inputs();
    start = 1'b1; tick(); idle_inputs();
    tick();
    pause = 3'b010;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold_state", 32'(state), 32'(S_HOLD));
      check("hold_count", 32'(count), 32'h0030);
    end
    pause = 3'b000;
    tick();
    check("resume_state", 32'(state), 32'(S_RUN));
    tick();
    check("resume_nostep", 32'(count), 32'h0030);
    tick();
    check("resume_count", 32'(count), 32'h0029);
    check("resume_step", 32'(step), 32'h1);

    // asynchronous reset mid-RUN
    load = 1'b1; preset = 16'h0042; tick(); idle_inputs();
    start = 1'b1; tick(); idle_inputs();
    tick(); tick();
    check("pre_rst_state", 32'(state), 32'(S_RUN));
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_count", 32'(count), 32'h0);
    check("arst_state", 32'(state), 32'(S_IDLE));
    check("arst_rz", 32'(reach_zero), 32'h1);
    check("arst_running", 32'(running), 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    check("post_rst_state", 32'(state), 32'(S_IDLE));

    // two-digit decimal instance, prescale 1
    load2 = 1'b1; preset2 = 8'h10; tick(); load2 = 1'b0;
    check("d2_load", 32'(count2), 32'h10);
    start2 = 1'b1; tick(); start2 = 1'b0;
    check("d2_run", 32'(state2), 32'(S_RUN));
    tick();
    check("d2_step_count", 32'(count2), 32'h09);
    check("d2_step_pulse", 32'(step2), 32'h1);
    tick();
    check("d2_next", 32'(count2), 32'h08);
    load2 = 1'b1; preset2 = 8'h7F; tick(); load2 = 1'b0;
    check("d2_clamp", 32'(count2), 32'h79);
    check("d2_clamp_state", 32'(state2), 32'(S_IDLE));

    // randomized run against the reference model
    use_model = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      load  = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      start = ($urandom_range(0, 5) == 0);
      for (int b = 0; b < 3; b++) pause[b] = ($urandom_range(0, 9) == 0);
      preset[3:0]   = 4'($urandom_range(0, 15));
      preset[7:4]   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      preset[11:8]  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      preset[15:12] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      tick();
    end
    idle_inputs();
    use_model = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
